// File: rtl/supernova_store_fwd_queue_if.sv
// Store-queue bus bundle: store insert, ROB commit, load-forward probes
// and the D-Cache write port.
//   slave  : the store queue side
//   master : memory-issue / ROB / D-Cache side (drives the *_in signals)
// Signal names keep the _in/_out suffixes as seen from the store queue.
interface supernova_store_fwd_queue_if #(
    parameter int XLEN      = 64,
    parameter int PA_W      = 56,
    parameter int ROB_IDX_W = 6,
    parameter int LD_PORTS  = 2
);
    localparam int LANE_B = XLEN / 8;

    // store insert
    logic                               alloc_valid_in;
    logic                               alloc_ready_out;
    logic [ROB_IDX_W-1:0]               alloc_rob_idx_in;
    logic [PA_W-1:0]                    alloc_pa_in;
    logic [XLEN-1:0]                    alloc_data_in;
    logic [1:0]                         alloc_size_in;
    // in-order commit
    logic                               commit_valid_in;
    logic [ROB_IDX_W-1:0]               commit_rob_idx_in;
    // load forwarding probes
    logic [LD_PORTS-1:0]                ld_valid_in;
    logic [LD_PORTS-1:0][PA_W-1:0]      ld_pa_in;
    logic [LD_PORTS-1:0][1:0]           ld_size_in;
    logic [LD_PORTS-1:0][ROB_IDX_W-1:0] ld_rob_idx_in;
    logic [LD_PORTS-1:0]                ld_fwd_hit_out;
    logic [LD_PORTS-1:0]                ld_fwd_conflict_out;
    logic [LD_PORTS-1:0][XLEN-1:0]      ld_fwd_data_out;
    // D-Cache write port
    logic                               dc_req_out;
    logic [PA_W-1:0]                    dc_addr_out;
    logic [XLEN-1:0]                    dc_wdata_out;
    logic [LANE_B-1:0]                  dc_wstrb_out;
    logic                               dc_ack_in;

    modport slave (
        input  alloc_valid_in, alloc_rob_idx_in, alloc_pa_in, alloc_data_in, alloc_size_in,
        output alloc_ready_out,
        input  commit_valid_in, commit_rob_idx_in,
        input  ld_valid_in, ld_pa_in, ld_size_in, ld_rob_idx_in,
        output ld_fwd_hit_out, ld_fwd_conflict_out, ld_fwd_data_out,
        output dc_req_out, dc_addr_out, dc_wdata_out, dc_wstrb_out,
        input  dc_ack_in
    );

    modport master (
        output alloc_valid_in, alloc_rob_idx_in, alloc_pa_in, alloc_data_in, alloc_size_in,
        input  alloc_ready_out,
        output commit_valid_in, commit_rob_idx_in,
        output ld_valid_in, ld_pa_in, ld_size_in, ld_rob_idx_in,
        input  ld_fwd_hit_out, ld_fwd_conflict_out, ld_fwd_data_out,
        input  dc_req_out, dc_addr_out, dc_wdata_out, dc_wstrb_out,
        output dc_ack_in
    );
endinterface

// File: rtl/supernova_store_fwd_queue.sv
// Store queue with byte-granular store-to-load forwarding, in-order commit
// marking and a post-commit drain engine toward the D-Cache write port.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_in        drop every uncommitted entry (tail <- commit pointer)
//   rob_head_in     ROB head, reference point for age compares
//   bus (slave)     insert / commit / load probes / D-Cache write port
//   count_out       occupancy (tail - head)
//   commit_err_out  sticky: a commit did not match the oldest uncommitted entry
//
// Build option: define SUPERNOVA_SQ_FWD_EN to enable data forwarding. Without
// it hit/data stay 0 and any overlapping older store raises conflict.
module supernova_store_fwd_queue #(
    parameter int DEPTH     = 8,
    parameter int XLEN      = 64,
    parameter int PA_W      = 56,
    parameter int ROB_IDX_W = 6,
    parameter int LD_PORTS  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_in,
    input  logic [ROB_IDX_W-1:0]         rob_head_in,
    supernova_store_fwd_queue_if.slave   bus,
    output logic [$clog2(DEPTH):0]       count_out,
    output logic                         commit_err_out
);
    localparam int LANE_B = XLEN / 8;
    localparam int OFF_W  = $clog2(LANE_B);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int LPA_W  = PA_W - OFF_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    // low (1<<size) bytes set
    function automatic logic [LANE_B-1:0] f_size_mask(input logic [1:0] size);
        f_size_mask = '0;
        for (int b = 0; b < LANE_B; b++)
            if (b < (1 << size)) f_size_mask[b] = 1'b1;
    endfunction

    // entry payload (validity comes from the pointers, so no reset needed)
    logic [LPA_W-1:0]     r_lpa  [DEPTH];
    logic [XLEN-1:0]      r_data [DEPTH];
    logic [LANE_B-1:0]    r_mask [DEPTH];
    logic [ROB_IDX_W-1:0] r_rob  [DEPTH];

    // head <= commit <= tail; [head,cptr) committed, [cptr,tail) uncommitted
    logic [PTR_W-1:0]     r_head, r_cptr, r_tail;
    logic                 r_err;
    logic [0:0]           r_state;
    logic                 r_dc_req;
    logic [PA_W-1:0]      r_dc_addr;
    logic [XLEN-1:0]      r_dc_wdata;
    logic [LANE_B-1:0]    r_dc_wstrb;

    logic [PTR_W-1:0]     w_count;
    logic                 w_ready, w_push, w_pop, w_cmt_ok;
    logic [IDX_W-1:0]     w_head_idx, w_cptr_idx, w_tail_idx;
    logic [OFF_W-1:0]     w_alloc_off;
    logic [DEPTH-1:0]     w_ent_vld;

    logic [LD_PORTS-1:0]           w_hit, w_conf;
    logic [LD_PORTS-1:0][XLEN-1:0] w_fdata;

    assign w_head_idx  = r_head[IDX_W-1:0];
    assign w_cptr_idx  = r_cptr[IDX_W-1:0];
    assign w_tail_idx  = r_tail[IDX_W-1:0];
    assign w_alloc_off = bus.alloc_pa_in[OFF_W-1:0];
    assign w_count     = r_tail - r_head;
    assign w_ready     = (w_count < PTR_W'(DEPTH));
    assign w_push      = bus.alloc_valid_in && w_ready && !flush_in;
    assign w_pop       = (r_state == S_REQ) && bus.dc_ack_in;
    assign w_cmt_ok    = bus.commit_valid_in && (r_cptr != r_tail)
                         && (r_rob[w_cptr_idx] == bus.commit_rob_idx_in);

    assign count_out           = w_count;
    assign commit_err_out      = r_err;
    assign bus.alloc_ready_out = w_ready;
    assign bus.dc_req_out      = r_dc_req;
    assign bus.dc_addr_out     = r_dc_addr;
    assign bus.dc_wdata_out    = r_dc_wdata;
    assign bus.dc_wstrb_out    = r_dc_wstrb;
    assign bus.ld_fwd_hit_out      = w_hit;
    assign bus.ld_fwd_conflict_out = w_conf;
    assign bus.ld_fwd_data_out     = w_fdata;

    // payload write: data and mask are stored already lane-aligned
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lpa[w_tail_idx]  <= bus.alloc_pa_in[PA_W-1:OFF_W];
            r_data[w_tail_idx] <= bus.alloc_data_in << {w_alloc_off, 3'b000};
            r_mask[w_tail_idx] <= f_size_mask(bus.alloc_size_in) << w_alloc_off;
            r_rob[w_tail_idx]  <= bus.alloc_rob_idx_in;
        end
    end

    // pointers; flush wins over insert and commit, drain pop is independent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_cptr <= '0;
            r_tail <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_pop) r_head <= r_head + PTR_W'(1);
            if (flush_in) begin
                r_tail <= r_cptr;
            end else begin
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                if (w_cmt_ok)                  r_cptr <= r_cptr + PTR_W'(1);
                else if (bus.commit_valid_in)  r_err  <= 1'b1;
            end
        end
    end

    // drain engine: the request payload is captured once and held until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dc_req   <= 1'b0;
            r_dc_addr  <= '0;
            r_dc_wdata <= '0;
            r_dc_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_head != r_cptr) begin
                        r_state    <= S_REQ;
                        r_dc_req   <= 1'b1;
                        r_dc_addr  <= {r_lpa[w_head_idx], {OFF_W{1'b0}}};
                        r_dc_wdata <= r_data[w_head_idx];
                        r_dc_wstrb <= r_mask[w_head_idx];
                    end
                end
                default: begin
                    if (bus.dc_ack_in) begin
                        r_state  <= S_IDLE;
                        r_dc_req <= 1'b0;
                    end
                end
            endcase
        end
    end

    // slot e is live when its distance from head is below the occupancy
    always_comb begin
        w_ent_vld = '0;
        for (int e = 0; e < DEPTH; e++)
            w_ent_vld[e] = {1'b0, IDX_W'(IDX_W'(e) - w_head_idx)} < w_count;
    end

`ifdef SUPERNOVA_SQ_FWD_EN
    function automatic logic [XLEN-1:0] f_byte_expand(input logic [LANE_B-1:0] m);
        for (int b = 0; b < LANE_B; b++) f_byte_expand[8*b +: 8] = {8{m[b]}};
    endfunction
`endif

    for (genvar p = 0; p < LD_PORTS; p++) begin : g_ld
        logic [OFF_W-1:0]     w_loff;
        logic [LANE_B-1:0]    w_lmask;
        logic [ROB_IDX_W-1:0] w_lage;
        logic [DEPTH-1:0]     w_cand;

        // ages are taken relative to the ROB head so the compare survives wrap
        always_comb begin
            w_loff  = bus.ld_pa_in[p][OFF_W-1:0];
            w_lmask = f_size_mask(bus.ld_size_in[p]) << w_loff;
            w_lage  = bus.ld_rob_idx_in[p] - rob_head_in;
            w_cand  = '0;
            for (int e = 0; e < DEPTH; e++)
                w_cand[e] = bus.ld_valid_in[p] && w_ent_vld[e]
                            && (ROB_IDX_W'(r_rob[e] - rob_head_in) < w_lage)
                            && (r_lpa[e] == bus.ld_pa_in[p][PA_W-1:OFF_W])
                            && (|(r_mask[e] & w_lmask));
        end

`ifdef SUPERNOVA_SQ_FWD_EN
        logic [IDX_W-1:0] w_idx, w_sel;
        logic             w_any, w_full;

        // walk head->tail; the last candidate seen is the youngest
        always_comb begin
            w_idx = '0;
            w_sel = '0;
            w_any = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = w_head_idx + IDX_W'(i);
                if (w_cand[w_idx]) begin
                    w_sel = w_idx;
                    w_any = 1'b1;
                end
            end
        end

        assign w_full     = ((r_mask[w_sel] & w_lmask) == w_lmask);
        assign w_hit[p]   = w_any && w_full;
        assign w_conf[p]  = w_any && !w_full;
        assign w_fdata[p] = (w_any && w_full)
                            ? ((r_data[w_sel] >> {w_loff, 3'b000})
                               & f_byte_expand(f_size_mask(bus.ld_size_in[p])))
                            : '0;
`else
        // no data path: any overlapping older store forces a replay
        assign w_hit[p]   = 1'b0;
        assign w_conf[p]  = |w_cand;
        assign w_fdata[p] = '0;
`endif
    end
endmodule
